// File: rtl/bus_req_agent.sv
// Requester endpoint for the global data bus: queues client packets,
// requests the bus, and issues the head packet the cycle after a grant.
// Ports: clk, rst_n, in_packet/_vld/_rdy (client side), bus_req,
// bus_grant, out_bus_packet (controller side), fifo_cnt, sent_cnt,
// starve, err_grant_empty, err_push_full (status).
package bus_pkg;
  typedef struct packed {
    logic [3:0]  core_addr;
    logic [1:0]  cmd;
    logic [15:0] data;
  } BUS_PACKET;
endpackage

module bus_req_agent
  import bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  BUS_PACKET                     in_packet,
  input  logic                          in_packet_vld,
  output logic                          in_packet_rdy,
  output logic                          bus_req,
  input  logic                          bus_grant,
  output BUS_PACKET                     out_bus_packet,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [15:0]                   sent_cnt,
  output logic                          starve,
  output logic                          err_grant_empty,
  output logic                          err_push_full
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WAIT_W-1:0] WMAX = '1;

  BUS_PACKET         mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  BUS_PACKET         out_q, out_d;
  logic [15:0]       sent_q, sent_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              egrant_q, egrant_d;
  logic              epush_q, epush_d;
  logic              issued_q, issued_d;
  logic              push, issue;

  assign in_packet_rdy   = (cnt_q < CW'(FIFO_DEPTH));
  assign bus_req         = (cnt_q != '0);
  assign out_bus_packet  = out_q;
  assign fifo_cnt        = cnt_q;
  assign sent_cnt        = sent_q;
  assign starve          = (wait_q == WMAX);
  assign err_grant_empty = egrant_q;
  assign err_push_full   = epush_q;

  always_comb begin
    push     = in_packet_vld && in_packet_rdy;
    issue    = bus_grant && bus_req;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    sent_d   = sent_q;
    wait_d   = wait_q;
    issued_d = issue;
    epush_d  = epush_q | (in_packet_vld && !in_packet_rdy);
    // A grant right after the last issue is the arbiter's pipeline lag.
    egrant_d = egrant_q | (bus_grant && !bus_req && !issued_q);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      out_d    = mem_q[rd_ptr_q];
      sent_d   = sent_q + 16'd1;
    end
    if (push && !issue) cnt_d = cnt_q + CW'(1);
    else if (!push && issue) cnt_d = cnt_q - CW'(1);
    if (bus_grant || !bus_req) wait_d = '0;
    else if (wait_q != WMAX) wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_packet;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      sent_q   <= '0;
      wait_q   <= '0;
      egrant_q <= 1'b0;
      epush_q  <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      sent_q   <= sent_d;
      wait_q   <= wait_d;
      egrant_q <= egrant_d;
      epush_q  <= epush_d;
      issued_q <= issued_d;
    end
  end
endmodule

// File: tb/tb_bus_req_agent.sv
// Bench for bus_req_agent: directed scenarios plus random traffic,
// checked against a queue-based reference model of the protocol.
module tb_bus_req_agent;
  import bus_pkg::*;

  localparam int DEPTH = 4;
  localparam int WMAX  = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  BUS_PACKET   in_packet = '0;
  logic        in_packet_vld = 1'b0;
  logic        in_packet_rdy;
  logic        bus_req;
  logic        bus_grant = 1'b0;
  BUS_PACKET   out_bus_packet;
  logic [2:0]  fifo_cnt;
  logic [15:0] sent_cnt;
  logic        starve;
  logic        err_grant_empty;
  logic        err_push_full;

  bus_req_agent #(.FIFO_DEPTH(DEPTH), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_packet(in_packet), .in_packet_vld(in_packet_vld),
    .in_packet_rdy(in_packet_rdy),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .out_bus_packet(out_bus_packet),
    .fifo_cnt(fifo_cnt), .sent_cnt(sent_cnt), .starve(starve),
    .err_grant_empty(err_grant_empty),
    .err_push_full(err_push_full)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  BUS_PACKET   q[$];
  BUS_PACKET   m_out;
  logic [15:0] m_sent;
  int          m_wait;
  logic        m_egrant, m_epush, m_prev_issue;
  BUS_PACKET   issued_log[$];
  BUS_PACKET   pushed_log[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    q.delete();
    m_out = '0; m_sent = '0; m_wait = 0;
    m_egrant = 0; m_epush = 0; m_prev_issue = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt"}, 32'(fifo_cnt), q.size());
    chk({tag, ".rdy"}, 32'(in_packet_rdy), 32'(q.size() < DEPTH));
    chk({tag, ".req"}, 32'(bus_req), 32'(q.size() != 0));
    chk({tag, ".out"}, 32'(out_bus_packet), 32'(m_out));
    chk({tag, ".sent"}, 32'(sent_cnt), 32'(m_sent));
    chk({tag, ".starve"}, 32'(starve), 32'(m_wait == WMAX));
    chk({tag, ".egrant"}, 32'(err_grant_empty), 32'(m_egrant));
    chk({tag, ".epush"}, 32'(err_push_full), 32'(m_epush));
  endtask

  // One clock: drive inputs, advance the model by the protocol rules,
  // then compare after the edge.
  task automatic cyc(input logic vld, input BUS_PACKET p,
                     input logic gnt, input string tag);
    bit rdy, req, iss, psh;
    in_packet = p; in_packet_vld = vld; bus_grant = gnt;
    rdy = q.size() < DEPTH;
    req = q.size() != 0;
    iss = gnt && req;
    psh = vld && rdy;
    if (vld && !rdy) m_epush = 1;
    if (gnt && !req && !m_prev_issue) m_egrant = 1;
    if (iss) begin
      m_out = q.pop_front();
      m_sent = m_sent + 16'd1;
      issued_log.push_back(m_out);
    end
    if (psh) begin
      q.push_back(p);
      pushed_log.push_back(p);
    end
    if (gnt || !req) m_wait = 0;
    else if (m_wait < WMAX) m_wait++;
    m_prev_issue = iss;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic BUS_PACKET rp();
    logic [21:0] r;
    r = 22'($urandom);
    return BUS_PACKET'(r);
  endfunction

  function automatic BUS_PACKET mk(input logic [3:0] a);
    BUS_PACKET p;
    p = rp();
    p.core_addr = a;
    return p;
  endfunction

  BUS_PACKET p0, p5, z;

  initial begin
    z = '0;
    m_reset();
    #12 rst_n = 1'b1;
    check_all("reset");

    p0 = mk(4'd3);
    cyc(1, p0, 0, "single.push");
    cyc(0, z, 0, "single.idle");
    cyc(0, z, 1, "single.grant");
    chk("single.out_is_p0", 32'(out_bus_packet), 32'(p0));
    cyc(0, z, 0, "single.after");
    chk("single.sent1", 32'(sent_cnt), 32'd1);

    cyc(1, mk(4'd1), 0, "late.push");
    cyc(0, z, 1, "late.issue");
    cyc(0, z, 1, "late.lategrant");
    chk("late.no_err", 32'(err_grant_empty), 32'd0);
    chk("late.sent2", 32'(sent_cnt), 32'd2);
    cyc(0, z, 0, "late.idle0");
    cyc(0, z, 0, "late.idle1");
    cyc(0, z, 1, "late.emptygrant");
    chk("late.err_set", 32'(err_grant_empty), 32'd1);

    for (int i = 0; i < 5; i++) begin
      if (i == 4) p5 = mk(4'd5);
      cyc(1, (i == 4) ? p5 : mk(4'(i)), 0, "fill");
    end
    chk("fill.cnt4", 32'(fifo_cnt), 32'd4);
    chk("fill.rdy0", 32'(in_packet_rdy), 32'd0);
    chk("fill.epush", 32'(err_push_full), 32'd1);
    issued_log.delete();
    for (int i = 0; i < 6; i++) cyc(0, z, 1, "drain");
    foreach (issued_log[i])
      chk("fill.p5_not_issued", 32'(issued_log[i] == p5), 32'd0);

    cyc(1, mk(4'd7), 0, "stream.pre0");
    cyc(1, mk(4'd8), 0, "stream.pre1");
    issued_log.delete();
    pushed_log.delete();
    for (int i = 0; i < 6; i++) begin
      cyc(1, mk(4'(i)), 1, "stream");
      chk("stream.cnt2", 32'(fifo_cnt), 32'd2);
    end
    chk("stream.n_issued", issued_log.size(), 32'd6);
    for (int i = 0; i < 6; i++) cyc(0, z, 1, "stream.drain");

    cyc(1, mk(4'd9), 0, "starve.push");
    for (int i = 0; i < 20; i++) cyc(0, z, 0, "starve.wait");
    chk("starve.set", 32'(starve), 32'd1);
    cyc(0, z, 1, "starve.grant");
    chk("starve.clr", 32'(starve), 32'd0);

    for (int i = 0; i < 3; i++) cyc(1, mk(4'(i)), 0, "ar.fill");
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    check_all("ar.low");
    #4 rst_n = 1'b1;
    in_packet_vld = 1'b0; bus_grant = 1'b0;
    p0 = mk(4'd2);
    cyc(1, p0, 0, "ar.push");
    cyc(0, z, 1, "ar.grant");
    chk("ar.out", 32'(out_bus_packet), 32'(p0));
    chk("ar.sent1", 32'(sent_cnt), 32'd1);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), rp(),
          ($urandom_range(0, 99) < 40), "rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bus_req_agent.md
Name: bus_req_agent

Overview:
- Requester-side endpoint of the global data bus arbitration protocol. One instance per bus client: it queues outgoing BUS_PACKETs in a small FIFO, raises its bus_req, and presents the head packet on its slice of the controller's packet array.
- Timing: the controller's grant in cycle c means the packet must be stable in cycle c+1. The controller samples it then and drives it on the bus one cycle later.
- Also provides status flags: queue occupancy, a starvation flag, and protocol-error flags.

Parameters:
- FIFO_DEPTH, 4, number of queued packets; power of two, ≥2.
- WAIT_W, 8, width of the starvation wait counter.
- Packet type: BUS_PACKET from the shared bus package. Not a parameter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_packet  in  BUS_PACKET  packet from the local client
- in_packet_vld  in  1  client push request
- in_packet_rdy  out  1  FIFO can accept a packet
- bus_req  out  1  to controller bus_req_array[k]
- bus_grant  in  1  from controller bus_grant_array[k]
- out_bus_packet  out  BUS_PACKET  to controller in_bus_packet_array[k]
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current occupancy
- sent_cnt  out  16  packets issued, wraps at 0xFFFF→0
- starve  out  1  wait counter saturated
- err_grant_empty  out  1  sticky: grant received while FIFO was empty
- err_push_full  out  1  sticky: push attempted while not ready

Behaviour:
- Reset (async, rst_n low): all outputs are 0, including out_bus_packet, fifo_cnt, sent_cnt and the flags. FIFO read/write pointers are cleared. Stored FIFO data need not be cleared.
- Combinational outputs:
  - in_packet_rdy = (fifo_cnt < FIFO_DEPTH).
  - bus_req = (fifo_cnt != 0).
  - Both are decoded from registers only. bus_grant never feeds bus_req, so there is no combinational loop through the arbiter.
- Push: when in_packet_vld && in_packet_rdy, at the clock edge in_packet is written at wr_ptr and wr_ptr increments (wrap mod FIFO_DEPTH).
- Push while full: when in_packet_vld && !in_packet_rdy, the packet is dropped and err_push_full sets (sticky until reset).
- Issue: when bus_grant && fifo_cnt != 0 at a clock edge:
  - out_bus_packet <= FIFO[rd_ptr];
  - rd_ptr increments;
  - sent_cnt increments.
  - The packet is therefore stable during the cycle after the grant, which is the cycle the controller samples it.
- Hold: out_bus_packet keeps its value until the next issue. It is never cleared between issues.
- Occupancy:
  - Push and issue on the same edge: fifo_cnt is unchanged and both pointers advance.
  - Push only: fifo_cnt +1.
  - Issue only: fifo_cnt −1.
- Last entry: when the last entry is issued, bus_req deasserts in the following cycle. The controller may still show bus_grant in that cycle because of its one-cycle grant pipeline. That late grant is ignored (no pop, no sent_cnt change) and does not set err_grant_empty.
- err_grant_empty: sets only when bus_grant is high, fifo_cnt == 0, and no issue happened on the previous edge. Sticky until reset.
- Back-to-back grants: consecutive grant cycles issue consecutive packets, one per cycle, in FIFO order.
- Starvation counter wait_cnt:
  - Clears on any edge with bus_grant.
  - Clears on any edge with bus_req low.
  - Otherwise increments, saturating at 2^WAIT_W−1.
  - starve = (wait_cnt == 2^WAIT_W−1), registered, and clears with the counter.
- Pointer widths are $clog2(FIFO_DEPTH). The count is one bit wider so the full and empty states are distinct.
- Reset mid-operation: queued packets are discarded, bus_req drops in the same cycle as rst_n falling (asynchronous), and out_bus_packet goes to 0.

Test Plan:
- Single packet. Reset, push P0 (core_addr=3), then hold bus_grant=1 for one cycle two cycles later.
  - Required: bus_req=1 from the cycle after the push.
  - Required: out_bus_packet==P0 in the cycle after the grant; bus_req=0 the cycle after that; sent_cnt=1; fifo_cnt=0.
- Fill and overflow. Push 5 packets back-to-back with no grant.
  - Required: fifo_cnt saturates at 4 and in_packet_rdy=0 after the 4th push.
  - Required: err_push_full=1 after the 5th push and the 5th packet is never issued.
- Streaming. With the FIFO holding 2 packets, keep bus_grant=1 for 6 cycles while pushing one packet per cycle.
  - Required: 6 packets appear on out_bus_packet in push order, one per cycle; fifo_cnt stays at 2.
- Late grant. Issue the only packet, then assert grant for one more cycle.
  - Required: no pop, sent_cnt unchanged, err_grant_empty stays 0.
  - Then a grant with an empty FIFO after two idle cycles: err_grant_empty=1.
- Starvation. With WAIT_W=4, hold bus_req high with no grant.
  - Required: starve=1 after 15 cycles; starve clears on the first grant.
- Async reset. Assert rst_n low for half a cycle with 3 packets queued.
  - Required: bus_req=0, fifo_cnt=0, and all outputs 0 immediately.
  - Required: after release, a new push is issued correctly with sent_cnt=1.
